matched_filter_controller: RTL and testbench

//  Sequencer for the matched-filter datapath (coefficient MIF ROM, x_t MIF ROM,

---
 rtl/mf_ctrl_pkg.sv | 19 +
 rtl/valid_delay_line.sv | 33 +++
 rtl/matched_filter_controller.sv | 205 ++++++++++++++++++++
 tb/tb_matched_filter_controller.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/mf_ctrl_pkg.sv
// Shared definitions for the matched-filter controller: sequencer state
// encodings and the MIF data-type identifiers used by the ROM images.
package mf_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        LOAD_COEFF = 3'd1,
        WAIT_COEFF = 3'd2,
        STREAM     = 3'd3,
        FLUSH      = 3'd4,
        DRAIN      = 3'd5,
        DONE       = 3'd6
    } mfState_e;

    // MIF data-type tags: which ROM image a read belongs to.
    localparam int unsigned COEFF   = 1;
    localparam int unsigned DATA_IN = 2;

endpackage

// File: rtl/valid_delay_line.sv
// Fixed-depth shift register for valid/qualifier bits travelling alongside the
// datapath. Output equals input delayed by DEPTH clock cycles; a synchronous
// clear empties every stage so that in-flight qualifiers vanish on an abort.
module valid_delay_line #(
    parameter int DEPTH = 1,
    parameter int WIDTH = 1
) (
    input  logic             clock,
    input  logic             resetN,
    input  logic             clear_i,
    input  logic [WIDTH-1:0] dataIn_i,
    output logic [WIDTH-1:0] dataOut_o
);

    logic [DEPTH-1:0][WIDTH-1:0] stage_q;

    // Shift one stage per cycle; clear drops everything in flight.
    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            stage_q <= '0;
        end else if (clear_i) begin
            stage_q <= '0;
        end else begin
            stage_q[0] <= dataIn_i;
            for (int i = 1; i < DEPTH; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign dataOut_o = stage_q[DEPTH-1];

endmodule

// File: rtl/matched_filter_controller.sv
// Sequencer for the matched-filter datapath. Loads the FIR coefficients from
// the coefficient ROM, waits for the loader to confirm, streams the x_t ROM
// into the FIR, flushes it with zeros and qualifies every valid filter output.
module matched_filter_controller
    import mf_ctrl_pkg::*;
#(
    parameter int COEFF_LENGTH  = 10000,
    parameter int DATA_LENGTH   = 33000,
    parameter int ADDR_WIDTH    = 16,
    parameter int CNT_WIDTH     = 17,
    parameter int ROM_LATENCY   = 1,
    parameter int FIR_LATENCY   = 4,
    parameter int COEFF_TIMEOUT = 64
) (
    input  logic                  clock,
    input  logic                  resetN,
    input  logic                  enable,
    input  logic                  abort,
    input  logic                  coeffSetFlag,
    output logic                  coeffRead,
    output logic [ADDR_WIDTH-1:0] coeffAddr,
    output logic                  dataRead,
    output logic [ADDR_WIDTH-1:0] dataAddr,
    output logic                  zeroInsert,
    output logic                  sampleValid,
    output logic                  outValid,
    output logic                  busy,
    output logic                  done,
    output logic                  error
);

    // Terminal counts for each phase. DRAIN is one shorter than the total
    // pipeline depth because the DONE cycle itself completes the drain, which
    // lands the done pulse on the final outValid.
    localparam logic [CNT_WIDTH-1:0] COEFF_LAST = CNT_WIDTH'(COEFF_LENGTH - 1);
    localparam logic [CNT_WIDTH-1:0] DATA_LAST  = CNT_WIDTH'(DATA_LENGTH - 1);
    localparam logic [CNT_WIDTH-1:0] FLUSH_LAST = CNT_WIDTH'(COEFF_LENGTH - 2);
    localparam logic [CNT_WIDTH-1:0] TIMER_LAST = CNT_WIDTH'(COEFF_TIMEOUT - 1);
    localparam logic [CNT_WIDTH-1:0] DRAIN_LAST = CNT_WIDTH'(ROM_LATENCY + FIR_LATENCY - 2);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX    = '1;

    mfState_e              state_q, state_d;
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d, cntInc;
    logic                  coeffRead_q, coeffRead_d;
    logic [ADDR_WIDTH-1:0] coeffAddr_q, coeffAddr_d;
    logic                  dataRead_q, dataRead_d;
    logic [ADDR_WIDTH-1:0] dataAddr_q, dataAddr_d;
    logic                  flush_q, flush_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  error_q, error_d;
    logic                  clearPipe;
    logic [1:0]            romStageIn, romStageOut;

    assign cntInc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_WIDTH'(1);

    // Next-state and registered-output decode; outputs follow the next state so
    // each strobe and address lines up with the state cycle it belongs to.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        error_d   = error_q;
        clearPipe = 1'b0;

        if (abort && (state_q != IDLE)) begin
            state_d   = IDLE;
            cnt_d     = '0;
            clearPipe = 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    if (enable && !abort) begin
                        state_d = LOAD_COEFF;
                        cnt_d   = '0;
                        error_d = 1'b0;
                    end
                end
                LOAD_COEFF: begin
                    if (cnt_q == COEFF_LAST) begin
                        state_d = WAIT_COEFF;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cntInc;
                    end
                end
                WAIT_COEFF: begin
                    if (coeffSetFlag) begin
                        state_d = STREAM;
                        cnt_d   = '0;
                    end else if (cnt_q == TIMER_LAST) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                        error_d = 1'b1;
                    end else begin
                        cnt_d = cntInc;
                    end
                end
                STREAM: begin
                    if (cnt_q == DATA_LAST) begin
                        state_d = FLUSH;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cntInc;
                    end
                end
                FLUSH: begin
                    if (cnt_q == FLUSH_LAST) begin
                        state_d = DRAIN;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cntInc;
                    end
                end
                DRAIN: begin
                    if (cnt_q == DRAIN_LAST) begin
                        state_d = DONE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cntInc;
                    end
                end
                DONE: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            endcase
        end

        coeffRead_d = (state_d == LOAD_COEFF);
        coeffAddr_d = coeffRead_d ? cnt_d[ADDR_WIDTH-1:0] : '0;
        dataRead_d  = (state_d == STREAM);
        dataAddr_d  = dataRead_d ? cnt_d[ADDR_WIDTH-1:0] : '0;
        flush_d     = (state_d == FLUSH);
        busy_d      = (state_d != IDLE);
        done_d      = (state_d == DONE);
    end

    // State, counter and output registers.
    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            coeffRead_q <= 1'b0;
            coeffAddr_q <= '0;
            dataRead_q  <= 1'b0;
            dataAddr_q  <= '0;
            flush_q     <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            coeffRead_q <= coeffRead_d;
            coeffAddr_q <= coeffAddr_d;
            dataRead_q  <= dataRead_d;
            dataAddr_q  <= dataAddr_d;
            flush_q     <= flush_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            error_q     <= error_d;
        end
    end

    // ROM reads and flush slots both become FIR input samples after the ROM
    // latency; the zero-select travels with them so flush follows data gaplessly.
    assign romStageIn = {flush_q, dataRead_q | flush_q};

    valid_delay_line #(
        .DEPTH (ROM_LATENCY),
        .WIDTH (2)
    ) u_romDelay (
        .clock     (clock),
        .resetN    (resetN),
        .clear_i   (clearPipe),
        .dataIn_i  (romStageIn),
        .dataOut_o (romStageOut)
    );

    valid_delay_line #(
        .DEPTH (FIR_LATENCY),
        .WIDTH (1)
    ) u_firDelay (
        .clock     (clock),
        .resetN    (resetN),
        .clear_i   (clearPipe),
        .dataIn_i  (romStageOut[0]),
        .dataOut_o (outValid)
    );

    assign zeroInsert  = romStageOut[1];
    assign sampleValid = romStageOut[0];
    assign coeffRead   = coeffRead_q;
    assign coeffAddr   = coeffAddr_q;
    assign dataRead    = dataRead_q;
    assign dataAddr    = dataAddr_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign error       = error_q;

endmodule

// File: tb/tb_matched_filter_controller.sv
// Testbench for matched_filter_controller with a small configuration
// (4 coefficients, 8 samples, ROM latency 1, FIR latency 3, timeout 8).
module tb_matched_filter_controller;

    localparam int COEFF_LENGTH  = 4;
    localparam int DATA_LENGTH   = 8;
    localparam int ADDR_WIDTH    = 16;
    localparam int CNT_WIDTH     = 17;
    localparam int ROM_LATENCY   = 1;
    localparam int FIR_LATENCY   = 3;
    localparam int COEFF_TIMEOUT = 8;

    logic                  clock = 1'b0;
    logic                  resetN;
    logic                  enable;
    logic                  abort;
    logic                  coeffSetFlag;
    logic                  coeffRead;
    logic [ADDR_WIDTH-1:0] coeffAddr;
    logic                  dataRead;
    logic [ADDR_WIDTH-1:0] dataAddr;
    logic                  zeroInsert;
    logic                  sampleValid;
    logic                  outValid;
    logic                  busy;
    logic                  done;
    logic                  error;
    logic [39:0]           actualOut;

    int testsRun    = 0;
    int testsFailed = 0;

    // One table row: inputs sampled at the next edge, outputs expected after it.
    typedef struct {
        logic        enable;
        logic        abort;
        logic        flag;
        logic [39:0] expected;
    } vec_t;

    vec_t vectors[$];

    matched_filter_controller #(
        .COEFF_LENGTH  (COEFF_LENGTH),
        .DATA_LENGTH   (DATA_LENGTH),
        .ADDR_WIDTH    (ADDR_WIDTH),
        .CNT_WIDTH     (CNT_WIDTH),
        .ROM_LATENCY   (ROM_LATENCY),
        .FIR_LATENCY   (FIR_LATENCY),
        .COEFF_TIMEOUT (COEFF_TIMEOUT)
    ) dut (
        .clock        (clock),
        .resetN       (resetN),
        .enable       (enable),
        .abort        (abort),
        .coeffSetFlag (coeffSetFlag),
        .coeffRead    (coeffRead),
        .coeffAddr    (coeffAddr),
        .dataRead     (dataRead),
        .dataAddr     (dataAddr),
        .zeroInsert   (zeroInsert),
        .sampleValid  (sampleValid),
        .outValid     (outValid),
        .busy         (busy),
        .done         (done),
        .error        (error)
    );

    always #5 clock = ~clock;

    assign actualOut = {coeffRead, coeffAddr, dataRead, dataAddr,
                        zeroInsert, sampleValid, outValid, busy, done, error};

    function automatic logic [39:0] makeOut(input logic cr, input int ca,
                                            input logic dr, input int da,
                                            input logic zi, input logic sv,
                                            input logic ov, input logic bz,
                                            input logic dn, input logic er);
        logic [15:0] caBits;
        logic [15:0] daBits;
        caBits  = ca[15:0];
        daBits  = da[15:0];
        makeOut = {cr, caBits, dr, daBits, zi, sv, ov, bz, dn, er};
    endfunction

    task automatic applyStimulus(input logic en, input logic ab, input logic fl);
        enable       = en;
        abort        = ab;
        coeffSetFlag = fl;
        @(posedge clock);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [39:0] exp);
        testsRun++;
        if (actualOut !== exp) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %h expected %h", name, actualOut, exp);
        end
    endtask

    // Full run schedule relative to the enable edge (row 0 = first LOAD cycle):
    // coeff reads rows 0-3, WAIT rows 4-5, flag sampled at row 6, data reads
    // rows 6-13, FLUSH rows 14-16, zeroInsert rows 15-17, sampleValid rows 7-17,
    // outValid rows 10-20, done row 20, IDLE row 21.
    task automatic buildRun(input logic holdEnable, input logic earlyFlag);
        vec_t v;
        for (int r = 0; r < 22; r++) begin
            v.enable   = (r == 0) || holdEnable;
            v.abort    = 1'b0;
            v.flag     = (r == 6) || (earlyFlag && r >= 1 && r <= 4);
            v.expected = makeOut(r <= 3, (r <= 3) ? r : 0,
                                 r >= 6 && r <= 13, (r >= 6 && r <= 13) ? r - 6 : 0,
                                 r >= 15 && r <= 17, r >= 7 && r <= 17,
                                 r >= 10 && r <= 20, r <= 20, r == 20, 1'b0);
            vectors.push_back(v);
        end
    endtask

    task automatic runTable(input string tag);
        for (int i = 0; i < vectors.size(); i++) begin
            applyStimulus(vectors[i].enable, vectors[i].abort, vectors[i].flag);
            checkOutput($sformatf("%s row %0d", tag, i), vectors[i].expected);
        end
    endtask

    // Safety net so the bench always ends even if something stalls.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        resetN       = 1'b1;
        enable       = 1'b0;
        abort        = 1'b0;
        coeffSetFlag = 1'b0;

        // Reset asserted between edges clears outputs, then IDLE holds.
        #2 resetN = 1'b0;
        #1 checkOutput("reset async", 40'h0);
        repeat (2) @(posedge clock);
        #1 checkOutput("reset held", 40'h0);
        @(negedge clock) resetN = 1'b1;
        for (int k = 0; k < 3; k++) begin
            applyStimulus(1'b0, 1'b0, 1'b0);
            checkOutput($sformatf("idle %0d", k), 40'h0);
        end

        // Nominal run, then a run with enable held (and early coeffSetFlag during
        // LOAD) running straight into a second nominal run.
        vectors.delete();
        buildRun(1'b0, 1'b0);
        buildRun(1'b1, 1'b1);
        buildRun(1'b0, 1'b0);
        runTable("main");

        // Coefficient timeout.
        applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput("timeout load0", makeOut(1, 0, 0, 0, 0, 0, 0, 1, 0, 0));
        repeat (4) applyStimulus(1'b0, 1'b0, 1'b0);
        for (int k = 1; k <= 7; k++) begin
            applyStimulus(1'b0, 1'b0, 1'b0);
            checkOutput($sformatf("timeout wait %0d", k), makeOut(0, 0, 0, 0, 0, 0, 0, 1, 0, 0));
        end
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("timeout expire", makeOut(0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
        applyStimulus(1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("error sticky", makeOut(0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
        applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput("error cleared", makeOut(1, 0, 0, 0, 0, 0, 0, 1, 0, 0));
        applyStimulus(1'b0, 1'b1, 1'b0);
        checkOutput("abort in load", 40'h0);

        // Abort while streaming at dataAddr 5.
        applyStimulus(1'b1, 1'b0, 1'b0);
        repeat (5) applyStimulus(1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b1);
        repeat (5) applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("stream addr5", makeOut(0, 0, 1, 5, 0, 1, 1, 1, 0, 0));
        applyStimulus(1'b0, 1'b1, 1'b0);
        checkOutput("abort in stream", 40'h0);
        for (int k = 0; k < 12; k++) begin
            applyStimulus(1'b0, 1'b0, 1'b0);
            checkOutput($sformatf("post abort %0d", k), 40'h0);
        end

        // Asynchronous reset in the middle of FLUSH.
        applyStimulus(1'b1, 1'b0, 1'b0);
        repeat (5) applyStimulus(1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b1);
        repeat (9) applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("mid flush", makeOut(0, 0, 0, 0, 1, 1, 1, 1, 0, 0));
        #2 resetN = 1'b0;
        #1 checkOutput("async reset flush", 40'h0);
        @(negedge clock) resetN = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("idle after reset", 40'h0);
        vectors.delete();
        buildRun(1'b0, 1'b0);
        runTable("rerun");

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
